// File: rtl/aemb_dwb_ram.sv
// Wishbone classic data-bus slave RAM with a programmable number of wait states.
// Byte lanes are big-endian: sel[3] steers dat[31:24], sel[0] steers dat[7:0].
module aemb_dwb_ram #(
    parameter int AW   = 10,
    parameter int WAIT = 0
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [AW-1:0] dwb_adr_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [31:0]   dwb_dat_i,
    output logic [31:0]   dwb_dat_o,
    output logic          dwb_ack_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam bit         NO_WAIT   = (WAIT == 0);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT == 0) ? 0 : WAIT - 1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_nxt_s;
    logic          latch_s;
    logic          enter_ack_s;

    logic [AW-1:0] adr_r;
    logic          wre_r;
    logic [3:0]    sel_r;
    logic [31:0]   dat_r;

    logic [AW-1:0] acc_adr_s;
    logic          acc_wre_s;
    logic [3:0]    acc_sel_s;
    logic [31:0]   acc_dat_s;

    logic [31:0]   mem [2**AW];

    // Next-state and wait-counter logic; a strobe at ACK exit starts a new request
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_ACK: begin
                if (dwb_stb_i) begin
                    latch_s = 1'b1;
                    if (NO_WAIT) begin
                        state_nxt_s = ST_ACK;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = WAIT_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (!dwb_stb_i) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_ACK;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // With no wait states the request is used on the same edge it is latched
    always_comb begin
        if (latch_s) begin
            acc_adr_s = dwb_adr_i;
            acc_wre_s = dwb_wre_i;
            acc_sel_s = dwb_sel_i;
            acc_dat_s = dwb_dat_i;
        end else begin
            acc_adr_s = adr_r;
            acc_wre_s = wre_r;
            acc_sel_s = sel_r;
            acc_dat_s = dat_r;
        end
    end

    assign enter_ack_s = (state_nxt_s == ST_ACK);

    // State, counter and request registers
    always_ff @(posedge gclk) begin
        if (grst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            adr_r   <= '0;
            wre_r   <= 1'b0;
            sel_r   <= 4'd0;
            dat_r   <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (latch_s) begin
                adr_r <= dwb_adr_i;
                wre_r <= dwb_wre_i;
                sel_r <= dwb_sel_i;
                dat_r <= dwb_dat_i;
            end
        end
    end

    // Byte-lane writes; contents survive reset
    always_ff @(posedge gclk) begin
        if (!grst && enter_ack_s && acc_wre_s) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel_s[i]) begin
                    mem[acc_adr_s][8*i +: 8] <= acc_dat_s[8*i +: 8];
                end
            end
        end
    end

    // Registered ack and read data; writes and empty-lane reads keep the old data
    always_ff @(posedge gclk) begin
        if (grst) begin
            dwb_ack_o <= 1'b0;
            dwb_dat_o <= 32'd0;
        end else begin
            dwb_ack_o <= enter_ack_s;
            if (enter_ack_s && !acc_wre_s && (acc_sel_s != 4'd0)) begin
                dwb_dat_o <= mem[acc_adr_s];
            end
        end
    end

endmodule

// File: tb/tb_aemb_dwb_ram.sv
// Self-checking bench: one RAM with no wait states, one with three, checked
// against a word-array model of memory contents and expected read data.
module tb_aemb_dwb_ram;

    logic        gclk;
    logic        grst;
    logic        stb  [2];
    logic        wre  [2];
    logic [9:0]  adr  [2];
    logic [3:0]  sel  [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        ack  [2];

    logic [31:0] mem_m  [2][1024];
    logic [31:0] dout_m [2];
    int          wait_of [2];
    int          n_vec;
    int          n_err;

    aemb_dwb_ram #(.AW(10), .WAIT(0)) u0 (
        .gclk(gclk), .grst(grst),
        .dwb_stb_i(stb[0]), .dwb_wre_i(wre[0]), .dwb_adr_i(adr[0]),
        .dwb_sel_i(sel[0]), .dwb_dat_i(din[0]),
        .dwb_dat_o(dout[0]), .dwb_ack_o(ack[0])
    );

    aemb_dwb_ram #(.AW(10), .WAIT(3)) u3 (
        .gclk(gclk), .grst(grst),
        .dwb_stb_i(stb[1]), .dwb_wre_i(wre[1]), .dwb_adr_i(adr[1]),
        .dwb_sel_i(sel[1]), .dwb_dat_i(din[1]),
        .dwb_dat_o(dout[1]), .dwb_ack_o(ack[1])
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic check_ack(input int d, input logic exp, input string name);
        n_vec++;
        if (ack[d] !== exp) begin
            $display("FAIL %s dut%0d: ack=%b expected %b", name, d, ack[d], exp);
            n_err++;
        end
    endtask

    task automatic check_dat(input int d, input logic [31:0] exp, input string name);
        n_vec++;
        if (dout[d] !== exp) begin
            $display("FAIL %s dut%0d: dat=%h expected %h", name, d, dout[d], exp);
            n_err++;
        end
    endtask

    // One complete transfer with latency, data and single-ack checks
    task automatic do_xfer(input int d, input logic w, input logic [9:0] a,
                           input logic [3:0] s, input logic [31:0] v);
        int lat;
        logic got;
        wre[d] = w; adr[d] = a; sel[d] = s; din[d] = v; stb[d] = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            got = ack[d];
        end
        stb[d] = 1'b0;
        if (w) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) mem_m[d][a][8*i +: 8] = v[8*i +: 8];
        end else if (s != 4'd0) begin
            dout_m[d] = mem_m[d][a];
        end
        n_vec++;
        if (!got || lat != wait_of[d] + 1) begin
            $display("FAIL latency dut%0d adr %0d: ack after %0d edges (seen=%b) expected %0d",
                     d, a, lat, got, wait_of[d] + 1);
            n_err++;
        end
        check_dat(d, dout_m[d], "xfer_data");
        tick();
        check_ack(d, 1'b0, "ack_single");
    endtask

    task automatic test_reset();
        grst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            stb[d] = 1'b1; wre[d] = 1'b1; adr[d] = 10'd0; sel[d] = 4'd0; din[d] = 32'd0;
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                check_ack(d, 1'b0, "reset_ack");
                check_dat(d, 32'd0, "reset_dat");
            end
        end
        grst = 1'b0;
        tick();
        check_ack(0, 1'b1, "first_ack_after_reset");
        check_ack(1, 1'b0, "no_early_ack_wait3");
        stb[0] = 1'b0;
        stb[1] = 1'b0;
        tick();
        check_ack(0, 1'b0, "ack_drop_after_reset");
        for (int c = 0; c < 5; c++) begin
            tick();
            check_ack(1, 1'b0, "aborted_after_reset");
        end
        dout_m[0] = 32'd0;
        dout_m[1] = 32'd0;
    endtask

    task automatic test_wait0();
        do_xfer(0, 1'b1, 10'd5, 4'b1111, 32'hDEADBEEF);
        do_xfer(0, 1'b0, 10'd5, 4'b1111, 32'd0);
        check_dat(0, 32'hDEADBEEF, "read_back");
        do_xfer(0, 1'b1, 10'd5, 4'b0100, 32'h00AA0000);
        do_xfer(0, 1'b0, 10'd5, 4'b1111, 32'd0);
        check_dat(0, 32'hDEAABEEF, "lane2_write");
        do_xfer(0, 1'b1, 10'd5, 4'b0001, 32'h00000011);
        do_xfer(0, 1'b0, 10'd5, 4'b1111, 32'd0);
        check_dat(0, 32'hDEAABE11, "lane0_write");
        do_xfer(0, 1'b0, 10'd5, 4'b0000, 32'd0);
        check_dat(0, 32'hDEAABE11, "empty_sel_hold");
        do_xfer(0, 1'b1, 10'd7, 4'b1111, 32'h12345678);
    endtask

    task automatic test_wait3();
        int lat;
        do_xfer(1, 1'b1, 10'd7, 4'b1111, 32'h12345678);
        do_xfer(1, 1'b0, 10'd7, 4'b1111, 32'd0);
        check_dat(1, 32'h12345678, "wait3_read");
        // strobe held past the ack: the follow-on request must not ack early
        wre[1] = 1'b0; adr[1] = 10'd7; sel[1] = 4'b1111; stb[1] = 1'b1;
        lat = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            lat++;
            check_ack(1, (c == 3) ? 1'b1 : 1'b0, "held_stb_ack");
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            check_ack(1, 1'b0, "held_stb_single");
        end
        stb[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_ack(1, 1'b0, "held_stb_abort");
        end
    endtask

    task automatic test_abort();
        do_xfer(1, 1'b1, 10'd9, 4'b1111, 32'h00000000);
        wre[1] = 1'b1; adr[1] = 10'd9; sel[1] = 4'b1111; din[1] = 32'hCAFEF00D; stb[1] = 1'b1;
        tick();
        check_ack(1, 1'b0, "abort_no_ack");
        tick();
        check_ack(1, 1'b0, "abort_no_ack");
        stb[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_ack(1, 1'b0, "abort_no_ack");
        end
        do_xfer(1, 1'b0, 10'd9, 4'b1111, 32'd0);
        check_dat(1, 32'h00000000, "abort_no_write");
    endtask

    task automatic test_back_to_back();
        wre[0] = 1'b0; adr[0] = 10'd5; sel[0] = 4'b1111; stb[0] = 1'b1;
        tick();
        check_ack(0, 1'b1, "b2b_ack1");
        check_dat(0, 32'hDEAABE11, "b2b_dat1");
        adr[0] = 10'd7;
        tick();
        check_ack(0, 1'b1, "b2b_ack2");
        check_dat(0, 32'h12345678, "b2b_dat2");
        stb[0] = 1'b0;
        tick();
        check_ack(0, 1'b0, "b2b_ack_fall");
        dout_m[0] = 32'h12345678;
    endtask

    task automatic test_reset_mid_wait();
        wre[1] = 1'b1; adr[1] = 10'd7; sel[1] = 4'b1111; din[1] = 32'hFFFFFFFF; stb[1] = 1'b1;
        tick();
        tick();
        grst = 1'b1;
        tick();
        check_ack(1, 1'b0, "rst_mid_ack");
        check_dat(1, 32'd0, "rst_mid_dat");
        grst = 1'b0;
        stb[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_ack(1, 1'b0, "rst_mid_no_ack");
        end
        dout_m[0] = 32'd0;
        dout_m[1] = 32'd0;
        do_xfer(1, 1'b0, 10'd7, 4'b1111, 32'd0);
        check_dat(1, 32'h12345678, "rst_mid_unchanged");
    endtask

    task automatic test_random();
        for (int d = 0; d < 2; d++)
            for (int a = 16; a < 32; a++)
                do_xfer(d, 1'b1, 10'(a), 4'b1111, $urandom);
        for (int n = 0; n < 80; n++) begin
            do_xfer(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    10'($urandom_range(31, 16)), 4'($urandom_range(15, 0)), $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        wait_of[0] = 0;
        wait_of[1] = 3;
        test_reset();
        test_wait0();
        test_wait3();
        test_abort();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aemb_dwb_ram.md
Name: aemb_dwb_ram

Overview:
- Wishbone classic data-bus slave: single-port synchronous RAM on the CPU data bus.
- Answers the core's dwb_stb_o / dwb_wre_o strobe with dwb_ack_o.
- Has a programmable wait-state counter so core stall handling can be exercised at any memory latency.
- Sits between the core's data port and on-chip data memory; byte lanes are big-endian.

Parameters:
- AW, 10: word-address width; depth = 2**AW words of 32 bits.
- WAIT, 0: wait states inserted before ack; legal range 0..15.

Ports:
- gclk  in  1  system clock; all state changes on rising edge.
- grst  in  1  reset; synchronous, active-high.
- dwb_stb_i  in  1  strobe/cycle from master; held until ack.
- dwb_wre_i  in  1  1 = write, 0 = read.
- dwb_adr_i  in  AW  word address; byte-address bits [AW+1:2].
- dwb_sel_i  in  4  byte lane enables; sel[3] = dat[31:24], sel[0] = dat[7:0].
- dwb_dat_i  in  32  write data.
- dwb_dat_o  out  32  read data; valid while dwb_ack_o = 1.
- dwb_ack_o  out  1  transfer acknowledge; registered, one cycle per transfer.

Behaviour:
- Reset (grst = 1 at an edge):
  - FSM goes to IDLE, wait counter = 0, dwb_ack_o = 0, dwb_dat_o = 0.
  - RAM contents are not cleared.
  - An in-flight transfer is dropped: no write, no ack. Reset overrides every other event.
- FSM states: IDLE, WAIT, ACK.
- IDLE, edge with dwb_stb_i = 1:
  - Latch adr, wre, sel and dat into request registers.
  - WAIT = 0: go to ACK.
  - Otherwise load counter = WAIT-1 and go to WAIT.
- WAIT:
  - Each edge with stb = 1: counter decrements.
  - Edge with counter = 0 and stb = 1: go to ACK.
  - Edge with stb = 0: abort. Go to IDLE with no write and no ack.
- Entering ACK: the access happens on that same edge, using the latched request.
  - Write: only lanes with sel = 1 are updated.
  - Read: dwb_dat_o <= RAM word at the latched address.
  - Write, or read with sel = 0000: dwb_dat_o holds its previous value.
  - dwb_ack_o = 1 for exactly the cycle spent in ACK.
- Latency: stb first sampled high at edge N gives ack high from edge N+1+WAIT to edge N+2+WAIT.
- ACK exit (back-to-back): the master reloads its strobe on the ack edge, so stb sampled high at the edge leaving ACK is a new request.
  - The new request is latched exactly as in IDLE.
  - With WAIT = 0, ack stays high on consecutive cycles, one transfer per cycle.
  - stb = 0 at that edge: go to IDLE, ack falls.
- dwb_ack_o is never asserted for a request whose stb dropped before completion.
- Inputs are only sampled at IDLE or ACK exit. Changes to adr/dat/sel/wre during WAIT are ignored.
- Address wraps naturally modulo 2**AW; there is no error response.
- Read-during-write: not possible, single outstanding transfer.

Test Plan:
1. Reset: grst held 2 cycles with stb = 1 -> dwb_ack_o = 0, dwb_dat_o = 0x00000000 throughout; first ack only after grst is released.
2. WAIT = 0:
   - Write adr 5, sel 1111, dat 0xDEADBEEF; stb at edge N -> ack high exactly cycle N+1.
   - Then read adr 5 -> ack one cycle, dwb_dat_o = 0xDEADBEEF.
3. Byte lanes, continuing from 2:
   - Write adr 5, sel 0100, dat 0x00AA0000 -> read adr 5 returns 0xDEAABEEF.
   - Write sel 0001, dat 0x00000011 -> read returns 0xDEAABE11.
4. WAIT = 3:
   - Read adr 7 (pre-written 0x12345678), stb at edge N -> ack 0 through N+3, ack 1 only at N+4, data 0x12345678.
   - Held stb gives exactly one ack.
5. Abort, WAIT = 3: write adr 9, dat 0xCAFEF00D; stb high 2 cycles then low -> no ack ever; later read adr 9 returns the old value 0x00000000 (pre-written).
6. Back-to-back, WAIT = 0:
   - stb held high; adr switches 5 -> 7 on the ack edge -> ack high two consecutive cycles with data 0xDEAABE11 then 0x12345678.
   - Then grst asserted during a WAIT = 3 write -> no ack and the target word is unchanged.
